mem_port_arbiter: RTL and testbench

- Shares one memory port between three requesters: CPU, DMA engine and accelerator.
- Sits between the requesters and the memory controller in the AFU.
- Round-robin grant, at most one request accepted per cycle; reads may be pipelined.
- Read responses return in order and are routed back to the issuing requester via an internal tag FIFO.

---
 rtl/mem_arb_pkg.sv | 42 ++++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_arb_tag_fifo.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the three-way memory port arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;
    localparam int REQ_ACL = 2;

    typedef logic [1:0] req_id_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } rr_sel_t;

    // First eligible requester scanning ptr, ptr+1, ptr+2 (mod 3).
    function automatic rr_sel_t rr_select(input logic [NUM_REQ-1:0] eligible, input req_id_t ptr);
        logic [NUM_REQ-1:0] rot;
        logic [2:0]         sum;
        rr_sel_t            res;
        // Rotate so that rot[0] is the requester at ptr.
        case (ptr)
            2'd1:    rot = {eligible[0], eligible[2], eligible[1]};
            2'd2:    rot = {eligible[1], eligible[0], eligible[2]};
            default: rot = eligible;
        endcase
        res.found = |rot;
        if (rot[0])      sum = {1'b0, ptr};
        else if (rot[1]) sum = {1'b0, ptr} + 3'd1;
        else if (rot[2]) sum = {1'b0, ptr} + 3'd2;
        else             sum = 3'd0;
        if (sum >= 3'd3) sum = sum - 3'd3;
        res.id = sum[1:0];
        return res;
    endfunction

    // Pointer value after requester id has been served.
    function automatic req_id_t rr_next(input req_id_t id);
        return (id == req_id_t'(NUM_REQ - 1)) ? req_id_t'(0) : id + 2'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundle of the memory port arbiter.
//
// Handshake: each requester raises req_en[i] with req_wr/req_addr/req_wdata
// and holds them stable; the transfer happens in the one cycle req_ready[i]
// is high. req_ready depends combinationally on mem_ready, so the
// requester-to-memory hand-off adds no cycle. On the memory side a request
// transfers in any cycle with mem_req && mem_ready; read data comes back
// in request order, one beat per mem_rvalid.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 28
);
    logic [NUM_REQ-1:0]                 req_en;
    logic [NUM_REQ-1:0]                 req_wr;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_data;
    logic                               mem_req;
    logic                               mem_wr;
    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic [DATA_WIDTH-1:0]              mem_wdata;
    logic                               mem_ready;
    logic                               mem_rvalid;
    logic [DATA_WIDTH-1:0]              mem_rdata;

    // Arbiter side.
    modport slave (
        input  req_en, req_wr, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_req, mem_wr, mem_addr, mem_wdata
    );

    // Requesters plus memory controller side.
    modport master (
        output req_en, req_wr, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_req, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of requester ids for reads that are still in flight.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  req_id_t                din,
    output req_id_t                dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    req_id_t       slots [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = slots[rd_ptr];

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between CPU, DMA and accelerator,
// with in-order routing of read responses back to the issuing requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 28,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    mem_port_arbiter_if.slave                bus,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             err_unexpected_rsp
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    req_id_t               rr_ptr;
    logic [NUM_REQ-1:0]    eligible;
    rr_sel_t               sel;
    logic                  accept;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  tag_push;
    logic                  tag_pop;
    logic                  tag_full;
    logic                  tag_empty;
    req_id_t               tag_head;
    logic [CW-1:0]         tag_count;

    // A full tag FIFO blocks readers only; writers never need a tag.
    assign eligible = bus.req_en & (bus.req_wr | {NUM_REQ{~tag_full}});
    assign sel      = rr_select(eligible, rr_ptr);
    assign accept   = sel.found && bus.mem_ready;
    assign tag_push = accept && !sel_wr;
    assign tag_pop  = bus.mem_rvalid && !tag_empty;

    // Mux the selected requester onto the memory port; zeros when idle.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel.found && sel.id == req_id_t'(i)) begin
                sel_wr    = bus.req_wr[i];
                sel_addr  = bus.req_addr[i];
                sel_wdata = bus.req_wdata[i];
            end
        end
    end

    assign bus.mem_req   = sel.found;
    assign bus.mem_wr    = sel_wr;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    // Handshake back to the requester whose request memory took this cycle.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = accept && (sel.id == req_id_t'(i));
        end
    end

    // Pointer moves only on an actual transfer, so a stall never skips anyone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= '0;
        else if (accept) rr_ptr <= rr_next(sel.id);
    end

    mem_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (sel.id),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    assign outstanding = tag_count;

    // Register read data one cycle and steer it by the head tag; a beat with
    // no read in flight is dropped and latched as an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid      <= '0;
            bus.rsp_data       <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            bus.rsp_valid <= tag_pop ? (NUM_REQ'(1) << tag_head) : '0;
            if (tag_pop) bus.rsp_data <= bus.mem_rdata;
            if (bus.mem_rvalid && tag_empty) err_unexpected_rsp <= 1'b1;
        end
    end

    a_req_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
    a_rsp_valid_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.rsp_valid));
    a_outstanding_max:   assert property (@(posedge clk) disable iff (rst)
                                          outstanding <= CW'(MAX_OUTSTANDING));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays all three requesters
// and the memory controller, and models the in-flight read tags as a queue.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int MO = 4;

    logic                  clk;
    logic                  rst;
    logic [$clog2(MO):0]   outstanding;
    logic                  err_unexpected_rsp;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .outstanding        (outstanding),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [1:0]    exp_q[$];
    logic [DW-1:0] last_data;
    logic          exp_err;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic [2:0] en, input logic [2:0] wr, input logic mem_ready);
        bus.req_en    = en;
        bus.req_wr    = wr;
        bus.mem_ready = mem_ready;
    endtask

    task automatic set_addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus.req_addr[0]  = a0;
        bus.req_addr[1]  = a1;
        bus.req_addr[2]  = a2;
        bus.req_wdata[0] = {4'hD, a0};
        bus.req_wdata[1] = {4'hD, a1};
        bus.req_wdata[2] = {4'hD, a2};
    endtask

    task automatic mem_rsp(input logic v, input logic [DW-1:0] d);
        bus.mem_rvalid = v;
        bus.mem_rdata  = d;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [2:0] exp_ready, input logic exp_req,
                             input logic exp_wr, input logic [AW-1:0] exp_addr);
        check({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_ready));
        check({tag, ".mem_req"}, 64'(bus.mem_req), 64'(exp_req));
        if (exp_req) begin
            check({tag, ".mem_wr"}, 64'(bus.mem_wr), 64'(exp_wr));
            check({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(exp_addr));
            check({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'({4'hD, exp_addr}));
        end else begin
            check({tag, ".mem_addr_idle"}, 64'(bus.mem_addr), 64'(0));
            check({tag, ".mem_wdata_idle"}, 64'(bus.mem_wdata), 64'(0));
        end
    endtask

    // Scoreboard step: predict the response of the coming edge from the
    // beat the bench is returning now, log any read accepted this cycle
    // (rd_grant = requester id, -1 for none), then clock and compare.
    task automatic advance(input int rd_grant);
        logic [2:0]    exp_v;
        logic [DW-1:0] exp_d;
        exp_v = 3'b000;
        exp_d = last_data;
        if (bus.mem_rvalid) begin
            if (exp_q.size() > 0) begin
                exp_v = 3'b001 << exp_q.pop_front();
                exp_d = bus.mem_rdata;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (rd_grant >= 0) exp_q.push_back(2'(rd_grant));
        tick();
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
        check("rsp_data", 64'(bus.rsp_data), 64'(exp_d));
        check("outstanding", 64'(outstanding), 64'(exp_q.size()));
        check("err_unexpected_rsp", 64'(err_unexpected_rsp), 64'(exp_err));
        last_data = exp_d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        exp_err   = 1'b0;
        last_data = '0;
        drive(3'b000, 3'b000, 1'b0);
        set_addrs(28'h0, 28'h0, 28'h0);
        mem_rsp(1'b0, '0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst.outstanding", 64'(outstanding), 64'(0));
        check("rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst.rsp_data", 64'(bus.rsp_data), 64'(0));
        check("rst.err", 64'(err_unexpected_rsp), 64'(0));
        check_bus("rst", 3'b000, 1'b0, 1'b0, 28'h0);
        rst = 1'b0;

        // Response routing: CPU read 0x10 then ACL read 0x20
        set_addrs(28'h10, 28'h11, 28'h20);
        drive(3'b001, 3'b000, 1'b1);
        settle(); check_bus("t3.cpu_rd", 3'b001, 1'b1, 1'b0, 28'h10);
        advance(REQ_CPU);
        drive(3'b100, 3'b000, 1'b1);
        settle(); check_bus("t3.acl_rd", 3'b100, 1'b1, 1'b0, 28'h20);
        advance(REQ_ACL);
        drive(3'b000, 3'b000, 1'b0);
        mem_rsp(1'b1, 32'hAAAA0001); advance(-1);
        mem_rsp(1'b1, 32'hBBBB0002); advance(-1);
        mem_rsp(1'b0, '0);           advance(-1);

        // Backpressure: pointer parked on DMA while memory stalls
        set_addrs(28'h100, 28'h101, 28'h102);
        drive(3'b001, 3'b001, 1'b1);
        settle(); check_bus("t4.cpu_wr", 3'b001, 1'b1, 1'b1, 28'h100);
        advance(-1);
        drive(3'b111, 3'b111, 1'b0);
        for (int c = 0; c < 5; c++) begin
            settle(); check_bus("t4.stall", 3'b000, 1'b1, 1'b1, 28'h101);
            advance(-1);
        end
        bus.mem_ready = 1'b1;
        settle(); check_bus("t4.dma_first", 3'b010, 1'b1, 1'b1, 28'h101);
        advance(-1);
        drive(3'b101, 3'b111, 1'b1);
        settle(); check_bus("t4.acl_next", 3'b100, 1'b1, 1'b1, 28'h102);
        advance(-1);
        drive(3'b001, 3'b111, 1'b1);
        settle(); check_bus("t4.cpu_next", 3'b001, 1'b1, 1'b1, 28'h100);
        advance(-1);

        // Round-robin fairness with continuous reads, drained every cycle
        set_addrs(28'h40, 28'h41, 28'h42);
        drive(3'b100, 3'b100, 1'b1);
        settle(); check_bus("t2.acl_wr", 3'b100, 1'b1, 1'b1, 28'h42);
        advance(-1);
        drive(3'b111, 3'b000, 1'b1);
        for (int c = 0; c < 6; c++) begin
            mem_rsp(c > 0, 32'hC0000000 + 32'(c));
            settle(); check_bus("t2.rr", 3'(3'b001 << (c % 3)), 1'b1, 1'b0, 28'h40 + 28'(c % 3));
            advance(c % 3);
        end
        drive(3'b000, 3'b000, 1'b0);
        mem_rsp(1'b1, 32'hC0000006); advance(-1);
        mem_rsp(1'b0, '0);

        // Push and pop in the same cycle with two reads in flight
        set_addrs(28'h50, 28'h51, 28'h52);
        drive(3'b001, 3'b000, 1'b1);
        settle(); check_bus("t6.cpu_rd", 3'b001, 1'b1, 1'b0, 28'h50);
        advance(REQ_CPU);
        drive(3'b010, 3'b000, 1'b1);
        settle(); check_bus("t6.dma_rd", 3'b010, 1'b1, 1'b0, 28'h51);
        advance(REQ_DMA);
        drive(3'b100, 3'b000, 1'b1);
        mem_rsp(1'b1, 32'h66660001);
        settle(); check_bus("t6.acl_rd_pop", 3'b100, 1'b1, 1'b0, 28'h52);
        advance(REQ_ACL);
        drive(3'b000, 3'b000, 1'b0);
        mem_rsp(1'b1, 32'h66660002); advance(-1);
        mem_rsp(1'b1, 32'h66660003); advance(-1);
        mem_rsp(1'b0, '0);

        // FIFO full: reads blocked, writes still pass
        set_addrs(28'h60, 28'h30, 28'h62);
        drive(3'b100, 3'b000, 1'b1); settle(); check_bus("t5.fill0", 3'b100, 1'b1, 1'b0, 28'h62); advance(REQ_ACL);
        drive(3'b001, 3'b000, 1'b1); settle(); check_bus("t5.fill1", 3'b001, 1'b1, 1'b0, 28'h60); advance(REQ_CPU);
        drive(3'b010, 3'b000, 1'b1); settle(); check_bus("t5.fill2", 3'b010, 1'b1, 1'b0, 28'h30); advance(REQ_DMA);
        drive(3'b100, 3'b000, 1'b1); settle(); check_bus("t5.fill3", 3'b100, 1'b1, 1'b0, 28'h62); advance(REQ_ACL);
        drive(3'b001, 3'b000, 1'b1);
        settle(); check_bus("t5.cpu_blocked", 3'b000, 1'b0, 1'b0, 28'h0);
        advance(-1);
        drive(3'b011, 3'b010, 1'b1);
        settle(); check_bus("t5.dma_wr", 3'b010, 1'b1, 1'b1, 28'h30);
        advance(-1);
        drive(3'b001, 3'b000, 1'b1);
        mem_rsp(1'b1, 32'h77770001);
        settle(); check_bus("t5.pop_no_free", 3'b000, 1'b0, 1'b0, 28'h0);
        advance(-1);
        mem_rsp(1'b0, '0);
        settle(); check_bus("t5.cpu_unblocked", 3'b001, 1'b1, 1'b0, 28'h60);
        advance(REQ_CPU);
        drive(3'b000, 3'b000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            mem_rsp(1'b1, 32'h77770002 + 32'(k));
            advance(-1);
        end
        mem_rsp(1'b0, '0);

        // Reset with three reads in flight, then a stale beat
        set_addrs(28'h80, 28'h81, 28'h82);
        drive(3'b111, 3'b000, 1'b1); settle(); check_bus("t1.rd0", 3'b010, 1'b1, 1'b0, 28'h81); advance(REQ_DMA);
        drive(3'b101, 3'b000, 1'b1); settle(); check_bus("t1.rd1", 3'b100, 1'b1, 1'b0, 28'h82); advance(REQ_ACL);
        drive(3'b001, 3'b000, 1'b1); settle(); check_bus("t1.rd2", 3'b001, 1'b1, 1'b0, 28'h80); advance(REQ_CPU);
        drive(3'b000, 3'b000, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        exp_err   = 1'b0;
        last_data = '0;
        tick();
        check("t1.rst.outstanding", 64'(outstanding), 64'(0));
        check("t1.rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("t1.rst.err", 64'(err_unexpected_rsp), 64'(0));
        check("t1.rst.rsp_data", 64'(bus.rsp_data), 64'(0));
        rst = 1'b0;
        mem_rsp(1'b1, 32'h99990001); advance(-1);
        mem_rsp(1'b0, '0);           advance(-1);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
